// File: rtl/led_fade_pkg.sv
// Shared types and defaults for the LED fade/PWM stage.
package led_fade_pkg;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RISE = 2'd1,
    CH_ON   = 2'd2,
    CH_FALL = 2'd3
  } ch_state_t;

  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned DEF_STEP_DIV = 256;

  function automatic int unsigned max_lvl(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// LED request/drive bundle between the blinker (master) and the fade stage (slave).
interface led_fade_pwm_if #(
  parameter int unsigned NUM_LEDS = 4
);
  logic [NUM_LEDS-1:0]   led_in;
  logic                  bypass;
  logic [NUM_LEDS-1:0]   led_out;
  logic                  busy;
  logic [2*NUM_LEDS-1:0] ch_state;

  modport master (output led_in, bypass, input led_out, busy, ch_state);
  modport slave  (input led_in, bypass, output led_out, busy, ch_state);
endinterface

// File: rtl/led_fade_channel.sv
// One fade channel: saturating level, state machine and PWM compare.
// Define LED_FADE_GAMMA_EN to compare against a squared (gamma-corrected) duty.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                led_in,
  input  logic                bypass,
  output logic                led_out,
  output ch_state_t           state
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_lvl(PWM_BITS));

  logic [PWM_BITS-1:0] lvl_q, lvl_d, duty;

  always_comb begin
    lvl_d = lvl_q;
    if (led_in && lvl_q != MAX) begin
      lvl_d = lvl_q + 1'b1;
    end else if (!led_in && lvl_q != '0) begin
      lvl_d = lvl_q - 1'b1;
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  always_comb begin
    sq   = {{PWM_BITS{1'b0}}, lvl_q} * {{PWM_BITS{1'b0}}, lvl_q};
    duty = sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  always_comb duty = lvl_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q   <= '0;
      state   <= CH_OFF;
      led_out <= 1'b0;
    end else begin
      // Full scale forced high so the top of the ramp has no off-cycle per period.
      led_out <= bypass ? led_in : ((lvl_q == MAX) || (pwm_cnt < duty));
      if (step) begin
        lvl_q <= lvl_d;
        if (led_in) begin
          state <= (lvl_d == MAX) ? CH_ON : CH_RISE;
        end else begin
          state <= (lvl_d == '0) ? CH_OFF : CH_FALL;
        end
      end
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade stage: shared step prescaler and PWM counter feeding per-channel faders.
// Optional LED_FADE_GAMMA_EN selects gamma-corrected duty in every channel.
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
  input logic            clk,
  input logic            rst,
  led_fade_pwm_if.slave  bus
);

  localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [PRE_W-1:0]    presc_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic                step;
  logic                busy_q;
  logic [NUM_LEDS-1:0] ramp;
  logic [NUM_LEDS-1:0] led_out_w;
  ch_state_t           st [NUM_LEDS];

  assign step = (presc_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= step ? '0 : presc_q + 1'b1;
      pwm_q   <= pwm_q + 1'b1;
      busy_q  <= |ramp;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .step    (step),
      .pwm_cnt (pwm_q),
      .led_in  (bus.led_in[i]),
      .bypass  (bus.bypass),
      .led_out (led_out_w[i]),
      .state   (st[i])
    );
    assign ramp[i] = (st[i] == CH_RISE) || (st[i] == CH_FALL);
    assign bus.ch_state[2*i+:2] = st[i];
  end

  assign bus.led_out = led_out_w;
  assign bus.busy    = busy_q;

endmodule
